div_unit: RTL and testbench

//   Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.

---
 rtl/div_unit_if.sv | 15 +
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between execute control and the iterative divider.
// No latency of its own; pure wiring.
// The divider ignores start while busy; the requester holds off using busy.
interface div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, op, a, b, input busy, done, result);
   modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Latency: WIDTH+1 cycles start->done; 1 cycle for divide-by-zero and signed overflow.
// No queueing: start while busy is dropped; the pipeline stalls on busy.
module div_unit #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, dvsr, result_r;
   logic             op_rem, neg_q, neg_r, done_r;

   logic             is_signed, sign_a, sign_b, b_zero, ovf, special;
   logic [WIDTH-1:0] abs_a, abs_b, spec_val;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] rem_nxt, quo_nxt, q_fin, r_fin;
   logic             accept, finish;

   // Operand decode for the request presented this cycle
   always_comb begin
      is_signed = ~bus.op[0];
      sign_a    = is_signed & bus.a[WIDTH-1];
      sign_b    = is_signed & bus.b[WIDTH-1];
      // the most negative value maps onto itself, which is its correct unsigned magnitude
      abs_a     = sign_a ? (~bus.a + 1'b1) : bus.a;
      abs_b     = sign_b ? (~bus.b + 1'b1) : bus.b;
      b_zero    = (bus.b == '0);
      ovf       = is_signed & (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.b);
      special   = b_zero | ovf;
      if (b_zero)
         spec_val = bus.op[1] ? bus.a : '1;
      else
         spec_val = bus.op[1] ? '0 : bus.a;
   end

   // One restoring step plus the sign fix-up applied on the final step
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      // partial remainder stays below the divisor, so bit WIDTH is a clean sign bit
      trial   = shifted - {1'b0, dvsr};
      if (!trial[WIDTH]) begin
         rem_nxt = trial[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end
      q_fin = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
      r_fin = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
   end

   // Next-state logic: accept only when idle, leave RUN after the last bit
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (!special) state_nxt = RUN;
            end
         end
         RUN: begin
            if (count == '0) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Datapath: operand load, iteration, and registered result/done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         op_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_r <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            if (special) begin
               result_r <= spec_val;
               done_r   <= 1'b1;
            end else begin
               rem    <= '0;
               quo    <= abs_a;
               dvsr   <= abs_b;
               count  <= CW'(WIDTH-1);
               op_rem <= bus.op[1];
               neg_q  <= sign_a ^ sign_b;
               neg_r  <= sign_a;
            end
         end else if (state == RUN) begin
            rem   <= rem_nxt;
            quo   <= quo_nxt;
            count <= count - 1'b1;
            if (finish) begin
               result_r <= op_rem ? r_fin : q_fin;
               done_r   <= 1'b1;
            end
         end
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = done_r;
   assign bus.result = result_r;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit at WIDTH=32.
// Cycle 0 is the cycle in which start is driven; outputs sampled 1 time unit after each rising edge.
// Every wait on done is bounded; an expired bound shows up as a latency of -1.
module tb_div_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   div_unit_if #(.WIDTH(32)) bus();

   div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Issue one request in cycle 0 and wait (bounded) for done.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int nbusy);
      bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
      lat = -1; nbusy = 0; res = 'x;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.busy) nbusy++;
         if (bus.done) begin
            lat = i; res = bus.result;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.result); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_unsigned;
      logic [31:0] r; int lat, nb;
      run_op(2'b01, 32'd100, 32'd7, r, lat, nb);
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency got %0d want 33", lat); end
      n_cmp++; if (nb !== 32) begin n_err++; $display("FAIL divu_busy_cycles got %0d want 32", nb); end
      n_cmp++; if (r !== 32'd14) begin n_err++; $display("FAIL divu_100_7 got %h want 0000000e", r); end
      @(posedge clk); #1;
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL divu_done_single got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL divu_result_held got %h want 0000000e", bus.result); end
      run_op(2'b11, 32'd100, 32'd7, r, lat, nb);
      n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL remu_100_7 got %h want 00000002", r); end
      run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, r, lat, nb);
      n_cmp++; if (r !== 32'h0 || lat !== 33) begin n_err++; $display("FAIL divu_min_allones got %h lat %0d want 0 lat 33", r, lat); end
   endtask

   task automatic test_signed;
      logic [31:0] r; int lat, nb;
      run_op(2'b00, 32'hFFFFFFF9, 32'd2, r, lat, nb);
      n_cmp++; if (r !== 32'hFFFFFFFD || lat !== 33) begin n_err++; $display("FAIL div_m7_2 got %h lat %0d want fffffffd lat 33", r, lat); end
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, r, lat, nb);
      n_cmp++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rem_m7_2 got %h want ffffffff", r); end
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, r, lat, nb);
      n_cmp++; if (r !== 32'd1) begin n_err++; $display("FAIL rem_7_m2 got %h want 00000001", r); end
      run_op(2'b00, 32'd7, 32'hFFFFFFFE, r, lat, nb);
      n_cmp++; if (r !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_7_m2 got %h want fffffffd", r); end
   endtask

   task automatic test_special;
      logic [31:0] r; int lat, nb;
      run_op(2'b00, 32'd5, 32'd0, r, lat, nb);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL div0_latency got %0d want 1", lat); end
      n_cmp++; if (nb !== 0) begin n_err++; $display("FAIL div0_busy got %0d want 0", nb); end
      n_cmp++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div0_result got %h want ffffffff", r); end
      run_op(2'b11, 32'd5, 32'd0, r, lat, nb);
      n_cmp++; if (r !== 32'd5 || lat !== 1) begin n_err++; $display("FAIL remu0 got %h lat %0d want 00000005 lat 1", r, lat); end
      run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, r, lat, nb);
      n_cmp++; if (r !== 32'h80000000 || lat !== 1) begin n_err++; $display("FAIL div_ovf got %h lat %0d want 80000000 lat 1", r, lat); end
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, r, lat, nb);
      n_cmp++; if (r !== 32'h0 || lat !== 1) begin n_err++; $display("FAIL rem_ovf got %h lat %0d want 0 lat 1", r, lat); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r; int lat, lat2;
      bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd10; bus.start = 1'b1;
      lat = -1; r = 'x;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         bus.start = (i == 5);
         if (i == 5) begin bus.a = 32'd9; bus.b = 32'd3; bus.op = 2'b00; end
         if (bus.done) begin lat = i; r = bus.result; break; end
      end
      n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ignore_start_latency got %0d want 33", lat); end
      n_cmp++; if (r !== 32'd100) begin n_err++; $display("FAIL ignore_start_result got %h want 00000064", r); end
      // new request issued in the done cycle
      bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
      lat2 = -1;
      for (int j = 1; j <= 100; j++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (j == 10) begin
            n_cmp++; if (bus.result !== 32'd100) begin n_err++; $display("FAIL b2b_result_held got %h want 00000064", bus.result); end
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
         end
         if (bus.done) begin lat2 = j; r = bus.result; break; end
      end
      n_cmp++; if (lat2 !== 33) begin n_err++; $display("FAIL b2b_latency got %0d want 33", lat2); end
      n_cmp++; if (r !== 32'd3) begin n_err++; $display("FAIL b2b_result got %h want 00000003", r); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] r; int lat, nb, pulses;
      bus.op = 2'b01; bus.a = 32'd1000; bus.b = 32'd10; bus.start = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL midreset_done got %b want 0", bus.done); end
      n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL midreset_result got %h want 0", bus.result); end
      @(posedge clk); #1;
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d pulses want 0", pulses); end
      run_op(2'b01, 32'd9, 32'd3, r, lat, nb);
      n_cmp++; if (r !== 32'd3 || lat !== 33) begin n_err++; $display("FAIL post_reset_divu got %h lat %0d want 00000003 lat 33", r, lat); end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      test_reset;
      test_unsigned;
      test_signed;
      test_special;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
